// File: rtl/mux_src_arbiter_if.sv
// Handshake bundle between the two sources, the arbiter and the downstream
// 2:1 mux. The arbiter connects through the slave modport; the environment
// (sources plus downstream sink) connects through the master modport.
interface mux_src_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;
  logic             sel;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, mux_a, mux_b, sel, out_valid
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, mux_a, mux_b, sel, out_valid
  );
endinterface

// File: rtl/mux_src_arbiter.sv
// Round-robin arbiter with bounded bursts between source channels A and B.
// The winning beat lands in a one-entry output register whose fields feed the
// downstream 2:1 mux directly (mux_a -> a, mux_b -> b, sel -> s).
module mux_src_arbiter #(
  parameter int WIDTH     = 1,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux_src_arbiter_if.slave    bus
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    burst_cnt;
  logic             last_grant_a;   // 1: A was granted most recently, 0: B
  logic             grant_entry;
  logic             load_en;
  logic             accept_a;
  logic             accept_b;

  logic             out_valid_q;
  logic             sel_q;
  logic [WIDTH-1:0] mux_a_q;
  logic [WIDTH-1:0] mux_b_q;

  // The output register may take a new beat when empty or draining this cycle.
  // Readies stop at BURST_LIM, which both saturates burst_cnt and forces the
  // one-cycle arbitration bubble at the end of a full burst.
  assign load_en     = !out_valid_q || bus.out_ready;
  assign bus.a_ready = (state == GRANT_A) && (burst_cnt < BURST_LIM) && load_en;
  assign bus.b_ready = (state == GRANT_B) && (burst_cnt < BURST_LIM) && load_en;
  assign accept_a    = bus.a_valid && bus.a_ready;
  assign accept_b    = bus.b_valid && bus.b_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.mux_a     = mux_a_q;
  assign bus.mux_b     = mux_b_q;

  // Next-state arbitration: fresh grants alternate on ties, a grant ends on a
  // full burst or when its source withdraws, and then passes to the other
  // channel if it is waiting.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.a_valid && (!bus.b_valid || !last_grant_a))
          state_nxt = GRANT_A;
        else if (bus.b_valid)
          state_nxt = GRANT_B;
      end
      GRANT_A: begin
        if ((burst_cnt == BURST_LIM) || !bus.a_valid)
          state_nxt = bus.b_valid ? GRANT_B : IDLE;
      end
      GRANT_B: begin
        if ((burst_cnt == BURST_LIM) || !bus.b_valid)
          state_nxt = bus.a_valid ? GRANT_A : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Any move into a grant state (from IDLE or from the other grant) opens a
  // new burst; staying in the same grant never does.
  assign grant_entry = (state_nxt != state) && (state_nxt != IDLE);

  // Arbitration state: FSM, beats taken in the current burst, tie-break memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      burst_cnt    <= '0;
      last_grant_a <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others, independent of order.
      state <= state_nxt;
      if (grant_entry) begin
        burst_cnt    <= '0;
        last_grant_a <= (state_nxt == GRANT_A);
      end else if (accept_a || accept_b) begin
        burst_cnt <= burst_cnt + CW'(1);
      end
    end
  end

  // One-entry output register: an accept overwrites the matching payload and
  // the select, a drain without an accept only clears the valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload registers are reset too because they drive the mux
      // inputs directly and must read zero after reset.
      out_valid_q <= 1'b0;
      sel_q       <= 1'b0;
      mux_a_q     <= '0;
      mux_b_q     <= '0;
    end else if (accept_a) begin
      mux_a_q     <= bus.a_data;
      sel_q       <= 1'b1;
      out_valid_q <= 1'b1;
    end else if (accept_b) begin
      mux_b_q     <= bus.b_data;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Self-checking bench for mux_src_arbiter. A cycle-level reference model of
// the arbitration rules predicts readies and the held output register, and
// pushes every accepted beat into a scoreboard; an independent monitor pops
// and compares whenever the downstream side consumes a beat.
module tb_mux_src_arbiter;

  localparam int W     = 4;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_src_arbiter_if #(.WIDTH(W)) bus ();

  mux_src_arbiter #(
    .WIDTH     (W),
    .BURST_MAX (BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         sel;
    logic [W-1:0] ma;
    logic [W-1:0] mb;
  } beat_t;

  beat_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = A, 2 = B; taken counts beats in
  // the current grant; last is the channel granted most recently.
  int           owner;
  int           taken;
  int           last;
  bit           held;
  logic         m_sel;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;

  always @(negedge clk) begin
    if (rst) begin
      owner = 0; taken = 0; last = 2; held = 0;
      m_sel = 1'b0; m_a = '0; m_b = '0;
      sb.delete();
    end else begin
      bit ra, rb, acc_a, acc_b, done, mine, other;
      bit room;
      room = (taken < BURST) && (!held || bus.out_ready);
      ra   = (owner == 1) && room;
      rb   = (owner == 2) && room;
      check("a_ready", 32'(bus.a_ready), 32'(ra));
      check("b_ready", 32'(bus.b_ready), 32'(rb));
      check("both_ready", 32'(bus.a_ready && bus.b_ready), 32'd0);
      check("out_valid", 32'(bus.out_valid), 32'(held));
      check("sel_held", 32'(bus.sel), 32'(m_sel));
      check("mux_a_held", 32'(bus.mux_a), 32'(m_a));
      check("mux_b_held", 32'(bus.mux_b), 32'(m_b));

      acc_a = ra && bus.a_valid;
      acc_b = rb && bus.b_valid;

      // Grant bookkeeping uses the beat count from before this cycle's accept.
      if (owner == 0) begin
        if (bus.a_valid && bus.b_valid) owner = (last == 1) ? 2 : 1;
        else if (bus.a_valid)           owner = 1;
        else if (bus.b_valid)           owner = 2;
        if (owner != 0) begin taken = 0; last = owner; end
      end else begin
        mine  = (owner == 1) ? bus.a_valid : bus.b_valid;
        other = (owner == 1) ? bus.b_valid : bus.a_valid;
        done  = (taken == BURST) || !mine;
        if (done) begin
          if (other) begin
            owner = 3 - owner; taken = 0; last = owner;
          end else begin
            owner = 0;
          end
        end else if (acc_a || acc_b) begin
          taken++;
        end
      end

      if (acc_a) begin
        m_a = bus.a_data; m_sel = 1'b1; held = 1;
        sb.push_back('{sel: 1'b1, ma: m_a, mb: m_b});
      end else if (acc_b) begin
        m_b = bus.b_data; m_sel = 1'b0; held = 1;
        sb.push_back('{sel: 1'b0, ma: m_a, mb: m_b});
      end else if (held && bus.out_ready) begin
        held = 0;
      end
    end
  end

  // Monitor: every consumed beat must be the oldest one the model accepted.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_sel", 32'(bus.sel), 32'(e.sel));
        check("beat_mux_a", 32'(bus.mux_a), 32'(e.ma));
        check("beat_mux_b", 32'(bus.mux_b), 32'(e.mb));
        check("beat_mux_y", 32'(bus.sel ? bus.mux_a : bus.mux_b),
              32'(e.sel ? e.ma : e.mb));
      end
    end
  end

  // Apply one input pattern just after a rising edge and hold it n cycles.
  task automatic step(input logic av, input logic [W-1:0] ad,
                      input logic bv, input logic [W-1:0] bd,
                      input logic ordy, input int n);
    @(posedge clk);
    #1;
    bus.a_valid   = av;
    bus.a_data    = ad;
    bus.b_valid   = bv;
    bus.b_data    = bd;
    bus.out_ready = ordy;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    logic acc_a, acc_b;
    bus.a_valid   = 1'b0;
    bus.a_data    = '0;
    bus.b_valid   = 1'b0;
    bus.b_data    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Tie straight out of reset: A wins first, bursts of four with bubbles.
    step(1, 4'h5, 1, 4'hA, 1, 24);
    step(0, 4'h0, 0, 4'h0, 1, 3);

    // Single A beat from idle.
    step(1, 4'h1, 0, 4'h0, 1, 2);
    step(0, 4'h0, 0, 4'h0, 1, 3);

    // Backpressure in the middle of an A burst.
    step(1, 4'h3, 0, 4'h0, 1, 3);
    step(1, 4'h3, 0, 4'h0, 0, 5);
    step(1, 4'h3, 0, 4'h0, 1, 6);
    step(0, 4'h0, 0, 4'h0, 1, 3);

    // Early release: two A beats, then A drops while B is waiting.
    step(1, 4'h6, 0, 4'h0, 1, 1);
    step(1, 4'h6, 0, 4'h0, 1, 1);
    step(1, 4'h9, 0, 4'h0, 1, 1);
    step(0, 4'h0, 1, 4'hC, 1, 2);
    step(0, 4'h0, 0, 4'h0, 1, 3);

    // Pass-through stream 1,0,1 on consecutive cycles.
    step(1, 4'h1, 0, 4'h0, 1, 2);
    step(1, 4'h0, 0, 4'h0, 1, 1);
    step(1, 4'h1, 0, 4'h0, 1, 1);
    step(0, 4'h0, 0, 4'h0, 1, 3);

    // Asynchronous reset while a beat is held.
    step(1, 4'h7, 0, 4'h0, 0, 4);
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_mux_a", 32'(bus.mux_a), 32'd0);
    check("rst_mux_b", 32'(bus.mux_b), 32'd0);
    check("rst_a_ready", 32'(bus.a_ready), 32'd0);
    check("rst_b_ready", 32'(bus.b_ready), 32'd0);
    bus.a_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(0, 4'h0, 0, 4'h0, 1, 4);

    // Randomized traffic honouring the source protocol.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      @(posedge clk);
      #1;
      if (!bus.a_valid || acc_a) begin
        bus.a_valid = ($urandom_range(0, 3) != 0);
        bus.a_data  = W'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        bus.a_valid = 1'b0;
      end
      if (!bus.b_valid || acc_b) begin
        bus.b_valid = ($urandom_range(0, 3) != 0);
        bus.b_data  = W'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        bus.b_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain and confirm every accepted beat was delivered.
    step(0, 4'h0, 0, 4'h0, 1, 10);
    @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_src_arbiter.md
Name: mux_src_arbiter

Overview:
- Upstream stage for the 2:1 select mux (`sub_module`). Arbitrates between two valid/ready source channels, A and B, using round-robin with a bounded burst length.
- Registers the winning beat into a one-entry output register that drives the mux inputs directly: `mux_a` feeds mux `a`, `mux_b` feeds mux `b`, `sel` feeds mux `s`. Mux `y` therefore always presents the granted beat.
- Downstream consumption uses `out_valid`/`out_ready`.

Parameters:
- WIDTH, 1, data width of each channel and of `mux_a`/`mux_b`. Must be >= 1.
- BURST_MAX, 4, maximum beats accepted per grant before the arbiter re-arbitrates. Must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  channel A beat available.
- a_data  input  WIDTH  channel A payload.
- a_ready  output  1  channel A beat accepted this cycle when high with a_valid.
- b_valid  input  1  channel B beat available.
- b_data  input  WIDTH  channel B payload.
- b_ready  output  1  channel B beat accepted this cycle when high with b_valid.
- mux_a  output  WIDTH  registered last A payload, to mux `a`.
- mux_b  output  WIDTH  registered last B payload, to mux `b`.
- sel  output  1  registered select, to mux `s`: 1 = A beat held, 0 = B beat held.
- out_valid  output  1  output register holds an unconsumed beat.
- out_ready  input  1  downstream accepts the held beat.

Behaviour:
- Reset values (async assert, sync deassert by `clk` domain): state=IDLE, burst_cnt=0, last_grant=B (so A wins the first tie), out_valid=0, sel=0, mux_a=0, mux_b=0. a_ready and b_ready are combinational and read 0 in IDLE.
- Reset mid-operation drops any held beat and any partial burst; no beat is emitted after reset until new input arrives.
- load_en = !out_valid || out_ready. Full-throughput pass-through: the register is refilled in the same cycle it drains.
- a_ready = (state==GRANT_A) && (burst_cnt < BURST_MAX) && load_en. b_ready is symmetric. Never both high.
- On an A accept: mux_a <= a_data, sel <= 1, out_valid <= 1, burst_cnt++. mux_b holds its value.
- On a B accept: mux_b <= b_data, sel <= 0, out_valid <= 1, burst_cnt++. mux_a holds its value.
- On `out_valid && out_ready` with no accept: out_valid <= 0. sel, mux_a and mux_b hold their values.
- burst_cnt width is $clog2(BURST_MAX+1). It saturates at BURST_MAX and never wraps.
- FSM states: IDLE, GRANT_A, GRANT_B.
  - IDLE:
    - Only a_valid is high: go to GRANT_A.
    - Only b_valid is high: go to GRANT_B.
    - Both are high: grant the channel != last_grant.
    - Neither is high: stay in IDLE.
  - GRANT_X, release condition: end = (burst_cnt==BURST_MAX) || !x_valid. Evaluated every cycle.
  - GRANT_X, on end:
    - If the other channel is valid, go to GRANT_other.
    - Otherwise go to IDLE.
  - GRANT_X, otherwise: stay.
  - Every grant entry sets burst_cnt <= 0 and last_grant <= entered channel.
  - The cycle in which BURST_MAX is reached has ready=0; this is a mandatory one-cycle arbitration bubble.
- Latency: with the block idle, valid asserted in cycle 0 gives ready=1 in cycle 1 and out_valid=1 with the beat on mux_a/mux_b/sel in cycle 2. After that, one beat per cycle while out_ready=1.
- Backpressure: when out_valid=1 and out_ready=0, both readies are 0. burst_cnt and the output register hold. The state holds unless the granted valid drops.
- Source protocol: once valid is high, payload is stable until ready. The block does not check this.
- Simultaneous drain and accept in one cycle: out_valid stays 1 and the new beat replaces the old one. No beat is lost or duplicated.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> all outputs read 0 immediately (async), state IDLE. After release with no valid, out_valid stays 0.
- Single A beat: a_valid=1, a_data=1 at cycle 0 from IDLE -> a_ready=1 in cycle 1; cycle 2 shows out_valid=1, sel=1, mux_a=1. With out_ready=1, out_valid returns to 0 in cycle 3.
- Tie, BURST_MAX=4, out_ready=1: both valid continuously -> A accepted 4 beats, one bubble cycle, B accepted 4 beats, bubble, A again. sel toggles 1,1,1,1,0,0,0,0 and readies are never both high.
- Backpressure: hold out_ready=0 for 5 cycles during an A burst -> a_ready=0 and the held mux_a/sel stay stable. On out_ready=1, the burst resumes from the held burst_cnt with no beat lost or duplicated.
- Early release: A sends 2 beats then drops a_valid while b_valid=1 -> next cycle is GRANT_B, and the B beat appears with sel=0 while mux_a retains the last A value.
- Pass-through: out_ready=1 and a continuous A stream of data 1,0,1 -> out_valid stays high and the mux output sequence is 1,0,1 on consecutive cycles.
